// File: rtl/rr_output_arbiter_if.sv
// Request/grant bundle between the input-port side of the router and one
// per-output-port round-robin arbiter.
interface rr_output_arbiter_if #(
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned CREDIT_W = 3
);
  localparam int unsigned IDX_W = $clog2(NUM_IN);

  logic [NUM_IN-1:0]        req_valid_i;
  logic [NUM_IN*ADDR_W-1:0] req_addr_i;
  logic [NUM_IN-1:0]        req_tail_i;
  logic                     credit_ret_i;
  logic [NUM_IN-1:0]        grant_o;
  logic [IDX_W-1:0]         grant_idx_o;
  logic                     busy_o;
  logic [CREDIT_W-1:0]      credits_o;
  logic                     timeout_o;

  // Requesters / credit source drive requests and observe grants.
  modport master (
    output req_valid_i, req_addr_i, req_tail_i, credit_ret_i,
    input  grant_o, grant_idx_o, busy_o, credits_o, timeout_o
  );

  // The arbiter consumes requests and produces grants.
  modport slave (
    input  req_valid_i, req_addr_i, req_tail_i, credit_ret_i,
    output grant_o, grant_idx_o, busy_o, credits_o, timeout_o
  );
endinterface

// File: rtl/rr_output_arbiter.sv
// Per-output-port round-robin arbiter with packet lock and downstream credits.
// Optional feature macro: RR_LOCK_TIMEOUT_EN -- forced release of a lock that
// sees no transfer for TIMEOUT consecutive cycles (timeout_o pulses).
// Without the macro, the lock is only released by the tail flit.
module rr_output_arbiter #(
  parameter int unsigned       NUM_IN      = 4,
  parameter int unsigned       ADDR_W      = 3,
  parameter logic [ADDR_W-1:0] PORT_ADDR   = ADDR_W'(1),
  parameter int unsigned       MAX_CREDITS = 4,
  parameter int unsigned       CREDIT_W    = 3,
  parameter int unsigned       TIMEOUT     = 16
) (
  input logic              clk,
  input logic              reset,
  rr_output_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_IN);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Reject configurations the datapath cannot represent.
  if (NUM_IN < 2 || MAX_CREDITS >= (1 << CREDIT_W) || MAX_CREDITS == 0 || TIMEOUT == 0) begin : g_bad_cfg
    $error("rr_output_arbiter: illegal parameter combination");
  end

  state_t              state;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    owner;
  logic [CREDIT_W-1:0] credits;

  logic [NUM_IN-1:0]   desire;
  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;
  logic [NUM_IN-1:0]   grant;
  logic                xfer;
  logic [IDX_W-1:0]    owner_next;

  // Which inputs want this output port this cycle.
  always_comb begin
    desire = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      desire[i] = bus.req_valid_i[i] & (bus.req_addr_i[i*ADDR_W +: ADDR_W] == PORT_ADDR);
    end
  end

  // First requester at or after the rotating pointer, wrapping.
  always_comb begin
    int unsigned scan;
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = 0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      scan = (32'(ptr) + k) % NUM_IN;
      if (!pick_found && desire[IDX_W'(scan)]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(scan);
      end
    end
  end

  // Grant the locked owner only when it has a flit and a downstream slot exists.
  always_comb begin
    grant = '0;
    if (state == LOCKED && desire[owner] && credits != '0) begin
      grant[owner] = 1'b1;
    end
  end

  assign xfer       = |grant;
  assign owner_next = (owner == IDX_W'(NUM_IN - 1)) ? '0 : owner + IDX_W'(1);

  assign bus.grant_o     = grant;
  assign bus.grant_idx_o = owner;
  assign bus.busy_o      = (state == LOCKED);
  assign bus.credits_o   = credits;

`ifdef RR_LOCK_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt;
  logic            timeout_q;
  assign bus.timeout_o = timeout_q;
`else
  assign bus.timeout_o = 1'b0;
`endif

  // Arbitration FSM, rotating pointer and credit counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      owner   <= '0;
      credits <= CREDIT_W'(MAX_CREDITS);
`ifdef RR_LOCK_TIMEOUT_EN
      idle_cnt  <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
`ifdef RR_LOCK_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      // A simultaneous return and transfer cancel out; returns saturate at the ceiling.
      if (xfer && !bus.credit_ret_i) begin
        credits <= credits - CREDIT_W'(1);
      end else if (!xfer && bus.credit_ret_i && credits != CREDIT_W'(MAX_CREDITS)) begin
        credits <= credits + CREDIT_W'(1);
      end

      if (state == IDLE) begin
        if (pick_found) begin
          owner <= pick_idx;
          state <= LOCKED;
        end
`ifdef RR_LOCK_TIMEOUT_EN
        idle_cnt <= '0;
`endif
      end else begin
        if (xfer && bus.req_tail_i[owner]) begin
          state <= IDLE;
          ptr   <= owner_next;
`ifdef RR_LOCK_TIMEOUT_EN
          idle_cnt <= '0;
`endif
        end
`ifdef RR_LOCK_TIMEOUT_EN
        else if (xfer) begin
          idle_cnt <= '0;
        end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
          timeout_q <= 1'b1;
          state     <= IDLE;
          ptr       <= owner_next;
          idle_cnt  <= '0;
        end else begin
          idle_cnt <= idle_cnt + TO_W'(1);
        end
`endif
      end
    end
  end

endmodule
